// File: rtl/c1_sound_mailbox.sv
// C1 sound mailbox: 68K-to-Z80 command FIFO and Z80-to-68K reply FIFO,
// each with sticky overflow, plus a Z80-side flush and a maskable registered NMI.
module c1_sound_mailbox #(
    parameter int DATA_W    = 8,
    parameter int CMD_DEPTH = 4,
    parameter int REP_DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       M68K_WR,
    input  logic                       M68K_RD,
    input  logic [DATA_W-1:0]          M68K_DIN,
    output logic [DATA_W-1:0]          M68K_DOUT,
    input  logic                       Z80_RD,
    input  logic                       Z80_WR,
    input  logic                       Z80_CLR,
    input  logic                       Z80_NMI_EN,
    input  logic                       Z80_NMI_DIS,
    input  logic [DATA_W-1:0]          Z80_DIN,
    output logic [DATA_W-1:0]          Z80_DOUT,
    output logic                       nNMI,
    output logic [$clog2(CMD_DEPTH):0] CMD_COUNT,
    output logic                       CMD_EMPTY,
    output logic                       CMD_FULL,
    output logic                       REP_EMPTY,
    output logic                       REP_FULL,
    output logic                       CMD_OVF,
    output logic                       REP_OVF
);

    // A depth-1 FIFO still gets a 1-bit pointer; its storage is rounded up to
    // 2**PW slots so the pointer indexes the array at its natural width.
    localparam int CMD_PW    = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int REP_PW    = (REP_DEPTH > 1) ? $clog2(REP_DEPTH) : 1;
    localparam int CMD_CW    = $clog2(CMD_DEPTH) + 1;
    localparam int REP_CW    = $clog2(REP_DEPTH) + 1;
    localparam int CMD_SLOTS = 1 << CMD_PW;
    localparam int REP_SLOTS = 1 << REP_PW;

    localparam logic [CMD_PW-1:0] CMD_LAST = CMD_PW'(CMD_DEPTH - 1);
    localparam logic [REP_PW-1:0] REP_LAST = REP_PW'(REP_DEPTH - 1);
    localparam logic [CMD_CW-1:0] CMD_MAX  = CMD_CW'(CMD_DEPTH);
    localparam logic [REP_CW-1:0] REP_MAX  = REP_CW'(REP_DEPTH);

    logic [DATA_W-1:0] cmd_mem_q [CMD_SLOTS];
    logic [DATA_W-1:0] cmd_mem_d [CMD_SLOTS];
    logic [CMD_PW-1:0] cmd_wr_ptr_q, cmd_wr_ptr_d;
    logic [CMD_PW-1:0] cmd_rd_ptr_q, cmd_rd_ptr_d;
    logic [CMD_CW-1:0] cmd_count_q, cmd_count_d;
    logic              cmd_ovf_q, cmd_ovf_d;

    logic [DATA_W-1:0] rep_mem_q [REP_SLOTS];
    logic [DATA_W-1:0] rep_mem_d [REP_SLOTS];
    logic [REP_PW-1:0] rep_wr_ptr_q, rep_wr_ptr_d;
    logic [REP_PW-1:0] rep_rd_ptr_q, rep_rd_ptr_d;
    logic [REP_CW-1:0] rep_count_q, rep_count_d;
    logic              rep_ovf_q, rep_ovf_d;

    logic              nmi_en_q, nmi_en_d;
    logic              nnmi_q, nnmi_d;

    logic cmd_empty, cmd_full, rep_empty, rep_full;
    logic cmd_push, cmd_pop, rep_push, rep_pop;

    assign cmd_empty = (cmd_count_q == '0);
    assign cmd_full  = (cmd_count_q == CMD_MAX);
    assign rep_empty = (rep_count_q == '0);
    assign rep_full  = (rep_count_q == REP_MAX);

    // A push into a full FIFO is accepted only when the same cycle frees a slot;
    // a flush overrides both strobes on the command side.
    always_comb begin
        cmd_push = M68K_WR && (!cmd_full || Z80_RD) && !Z80_CLR;
        cmd_pop  = Z80_RD && !cmd_empty && !Z80_CLR;
        rep_push = Z80_WR && (!rep_full || M68K_RD);
        rep_pop  = M68K_RD && !rep_empty;
    end

    always_comb begin
        cmd_mem_d    = cmd_mem_q;
        cmd_wr_ptr_d = cmd_wr_ptr_q;
        cmd_rd_ptr_d = cmd_rd_ptr_q;
        cmd_count_d  = cmd_count_q;
        cmd_ovf_d    = cmd_ovf_q;
        if (Z80_CLR) begin
            cmd_wr_ptr_d = '0;
            cmd_rd_ptr_d = '0;
            cmd_count_d  = '0;
            cmd_ovf_d    = 1'b0;
        end else begin
            if (cmd_push) begin
                cmd_mem_d[cmd_wr_ptr_q] = M68K_DIN;
                cmd_wr_ptr_d = (cmd_wr_ptr_q == CMD_LAST) ? '0 : cmd_wr_ptr_q + CMD_PW'(1);
            end
            if (cmd_pop) begin
                cmd_rd_ptr_d = (cmd_rd_ptr_q == CMD_LAST) ? '0 : cmd_rd_ptr_q + CMD_PW'(1);
            end
            if (cmd_push && !cmd_pop) begin
                cmd_count_d = cmd_count_q + CMD_CW'(1);
            end else if (cmd_pop && !cmd_push) begin
                cmd_count_d = cmd_count_q - CMD_CW'(1);
            end
            if (M68K_WR && cmd_full && !Z80_RD) begin
                cmd_ovf_d = 1'b1;
            end
        end
    end

    // Reply overflow clears on a 68K read that observes it set; the pop itself
    // behaves normally, and overflow can never be set in the same cycle.
    always_comb begin
        rep_mem_d    = rep_mem_q;
        rep_wr_ptr_d = rep_wr_ptr_q;
        rep_rd_ptr_d = rep_rd_ptr_q;
        rep_count_d  = rep_count_q;
        rep_ovf_d    = rep_ovf_q;
        if (rep_push) begin
            rep_mem_d[rep_wr_ptr_q] = Z80_DIN;
            rep_wr_ptr_d = (rep_wr_ptr_q == REP_LAST) ? '0 : rep_wr_ptr_q + REP_PW'(1);
        end
        if (rep_pop) begin
            rep_rd_ptr_d = (rep_rd_ptr_q == REP_LAST) ? '0 : rep_rd_ptr_q + REP_PW'(1);
        end
        if (rep_push && !rep_pop) begin
            rep_count_d = rep_count_q + REP_CW'(1);
        end else if (rep_pop && !rep_push) begin
            rep_count_d = rep_count_q - REP_CW'(1);
        end
        if (Z80_WR && rep_full && !M68K_RD) begin
            rep_ovf_d = 1'b1;
        end else if (M68K_RD && rep_ovf_q) begin
            rep_ovf_d = 1'b0;
        end
    end

    // Disable wins over enable; the NMI request is built from registered state
    // so it trails the FIFO/enable update by one cycle.
    always_comb begin
        nmi_en_d = nmi_en_q;
        if (Z80_NMI_DIS) begin
            nmi_en_d = 1'b0;
        end else if (Z80_NMI_EN) begin
            nmi_en_d = 1'b1;
        end
        nnmi_d = ~(nmi_en_q & ~cmd_empty);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < CMD_SLOTS; i++) begin
                cmd_mem_q[i] <= '0;
            end
            for (int i = 0; i < REP_SLOTS; i++) begin
                rep_mem_q[i] <= '0;
            end
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
            cmd_count_q  <= '0;
            cmd_ovf_q    <= 1'b0;
            rep_wr_ptr_q <= '0;
            rep_rd_ptr_q <= '0;
            rep_count_q  <= '0;
            rep_ovf_q    <= 1'b0;
            nmi_en_q     <= 1'b0;
            nnmi_q       <= 1'b1;
        end else begin
            cmd_mem_q    <= cmd_mem_d;
            rep_mem_q    <= rep_mem_d;
            cmd_wr_ptr_q <= cmd_wr_ptr_d;
            cmd_rd_ptr_q <= cmd_rd_ptr_d;
            cmd_count_q  <= cmd_count_d;
            cmd_ovf_q    <= cmd_ovf_d;
            rep_wr_ptr_q <= rep_wr_ptr_d;
            rep_rd_ptr_q <= rep_rd_ptr_d;
            rep_count_q  <= rep_count_d;
            rep_ovf_q    <= rep_ovf_d;
            nmi_en_q     <= nmi_en_d;
            nnmi_q       <= nnmi_d;
        end
    end

    assign Z80_DOUT  = cmd_empty ? '0 : cmd_mem_q[cmd_rd_ptr_q];
    assign M68K_DOUT = rep_empty ? '0 : rep_mem_q[rep_rd_ptr_q];
    assign CMD_COUNT = cmd_count_q;
    assign CMD_EMPTY = cmd_empty;
    assign CMD_FULL  = cmd_full;
    assign REP_EMPTY = rep_empty;
    assign REP_FULL  = rep_full;
    assign CMD_OVF   = cmd_ovf_q;
    assign REP_OVF   = rep_ovf_q;
    assign nNMI      = nnmi_q;

endmodule

// File: tb/tb_c1_sound_mailbox.sv
// Directed bench for c1_sound_mailbox (command depth 4, single-entry reply latch).
module tb_c1_sound_mailbox;

    logic       CLK = 1'b0;
    logic       RESET, M68K_WR, M68K_RD, Z80_RD, Z80_WR, Z80_CLR, Z80_NMI_EN, Z80_NMI_DIS;
    logic [7:0] M68K_DIN, Z80_DIN, M68K_DOUT, Z80_DOUT;
    logic       nNMI, CMD_EMPTY, CMD_FULL, REP_EMPTY, REP_FULL, CMD_OVF, REP_OVF;
    logic [2:0] CMD_COUNT;

    int totalChecks = 0;
    int badChecks   = 0;

    always #5 CLK = ~CLK;

    c1_sound_mailbox #(.DATA_W(8), .CMD_DEPTH(4), .REP_DEPTH(1)) dut (
        .CLK(CLK), .RESET(RESET),
        .M68K_WR(M68K_WR), .M68K_RD(M68K_RD), .M68K_DIN(M68K_DIN), .M68K_DOUT(M68K_DOUT),
        .Z80_RD(Z80_RD), .Z80_WR(Z80_WR), .Z80_CLR(Z80_CLR),
        .Z80_NMI_EN(Z80_NMI_EN), .Z80_NMI_DIS(Z80_NMI_DIS),
        .Z80_DIN(Z80_DIN), .Z80_DOUT(Z80_DOUT), .nNMI(nNMI), .CMD_COUNT(CMD_COUNT),
        .CMD_EMPTY(CMD_EMPTY), .CMD_FULL(CMD_FULL), .REP_EMPTY(REP_EMPTY), .REP_FULL(REP_FULL),
        .CMD_OVF(CMD_OVF), .REP_OVF(REP_OVF)
    );

    // every comparison funnels through here
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one clock: strobes set beforehand are sampled on this edge, then cleared
    task automatic applyStimulus();
        @(posedge CLK);
        #1;
        M68K_WR = 0; M68K_RD = 0; Z80_RD = 0; Z80_WR = 0;
        Z80_CLR = 0; Z80_NMI_EN = 0; Z80_NMI_DIS = 0;
    endtask

    task automatic pushCmd(input logic [7:0] v);
        M68K_WR = 1; M68K_DIN = v;
        applyStimulus();
    endtask

    task automatic popCmdExpect(input string tag, input logic [7:0] exp);
        checkOutput(tag, Z80_DOUT, exp);
        Z80_RD = 1;
        applyStimulus();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_count"}, CMD_COUNT, 0);
        checkOutput({tag, "_cmdEmpty"}, CMD_EMPTY, 1);
        checkOutput({tag, "_cmdFull"}, CMD_FULL, 0);
        checkOutput({tag, "_repEmpty"}, REP_EMPTY, 1);
        checkOutput({tag, "_repFull"}, REP_FULL, 0);
        checkOutput({tag, "_cmdOvf"}, CMD_OVF, 0);
        checkOutput({tag, "_repOvf"}, REP_OVF, 0);
        checkOutput({tag, "_nNMI"}, nNMI, 1);
        checkOutput({tag, "_z80Dout"}, Z80_DOUT, 0);
        checkOutput({tag, "_m68kDout"}, M68K_DOUT, 0);
    endtask

    initial begin
        RESET = 1; M68K_WR = 0; M68K_RD = 0; Z80_RD = 0; Z80_WR = 0;
        Z80_CLR = 0; Z80_NMI_EN = 0; Z80_NMI_DIS = 0; M68K_DIN = 0; Z80_DIN = 0;
        applyStimulus();
        applyStimulus();
        RESET = 0;
        checkResetState("reset");

        // in-order delivery of three commands
        pushCmd(8'h11); pushCmd(8'h22); pushCmd(8'h33);
        checkOutput("seq_count", CMD_COUNT, 3);
        popCmdExpect("seq_head0", 8'h11);
        popCmdExpect("seq_head1", 8'h22);
        popCmdExpect("seq_head2", 8'h33);
        checkOutput("seq_empty", CMD_EMPTY, 1);
        checkOutput("seq_doutZero", Z80_DOUT, 0);

        // fill, overflow, push+pop while full
        for (int i = 0; i < 4; i++) pushCmd(8'hA0 + 8'(i));
        checkOutput("fill_full", CMD_FULL, 1);
        checkOutput("fill_count", CMD_COUNT, 4);
        pushCmd(8'hFF);
        checkOutput("ovf_flag", CMD_OVF, 1);
        checkOutput("ovf_count", CMD_COUNT, 4);
        checkOutput("ovf_head", Z80_DOUT, 8'hA0);
        M68K_WR = 1; M68K_DIN = 8'hB4; Z80_RD = 1;
        applyStimulus();
        checkOutput("pp_count", CMD_COUNT, 4);
        checkOutput("pp_head", Z80_DOUT, 8'hA1);
        popCmdExpect("drain0", 8'hA1);
        popCmdExpect("drain1", 8'hA2);
        popCmdExpect("drain2", 8'hA3);
        popCmdExpect("drainTail", 8'hB4);
        checkOutput("drain_empty", CMD_EMPTY, 1);
        checkOutput("ovf_sticky", CMD_OVF, 1);
        Z80_CLR = 1;
        applyStimulus();
        checkOutput("clr_ovf", CMD_OVF, 0);

        // push and pop together on an empty FIFO: only the push takes effect
        M68K_WR = 1; M68K_DIN = 8'h66; Z80_RD = 1;
        applyStimulus();
        checkOutput("emptyPP_count", CMD_COUNT, 1);
        popCmdExpect("emptyPP_head", 8'h66);

        // NMI timing
        Z80_NMI_EN = 1;
        applyStimulus();
        checkOutput("nmi_idle", nNMI, 1);
        pushCmd(8'h5A);
        checkOutput("nmi_edgeN", nNMI, 1);
        applyStimulus();
        checkOutput("nmi_low", nNMI, 0);
        Z80_RD = 1;
        applyStimulus();
        checkOutput("nmi_popEdge", nNMI, 0);
        applyStimulus();
        checkOutput("nmi_afterPop", nNMI, 1);
        pushCmd(8'h5B);
        applyStimulus();
        checkOutput("nmi_low2", nNMI, 0);
        Z80_NMI_DIS = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("nmi_dis", nNMI, 1);
        Z80_NMI_EN = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("nmi_reen", nNMI, 0);
        Z80_NMI_EN = 1; Z80_NMI_DIS = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("nmi_bothDis", nNMI, 1);
        Z80_CLR = 1;
        applyStimulus();

        // flush beats a coincident push
        pushCmd(8'h01); pushCmd(8'h02);
        Z80_CLR = 1; M68K_WR = 1; M68K_DIN = 8'h77;
        applyStimulus();
        checkOutput("flush_empty", CMD_EMPTY, 1);
        checkOutput("flush_ovf", CMD_OVF, 0);
        checkOutput("flush_count", CMD_COUNT, 0);
        checkOutput("flush_dout", Z80_DOUT, 0);

        // single-entry reply latch
        Z80_WR = 1; Z80_DIN = 8'h42;
        applyStimulus();
        checkOutput("rep_head", M68K_DOUT, 8'h42);
        checkOutput("rep_full", REP_FULL, 1);
        Z80_WR = 1; Z80_DIN = 8'h43;
        applyStimulus();
        checkOutput("rep_ovf", REP_OVF, 1);
        checkOutput("rep_headKept", M68K_DOUT, 8'h42);
        M68K_RD = 1;
        applyStimulus();
        checkOutput("rep_empty", REP_EMPTY, 1);
        checkOutput("rep_ovfClr", REP_OVF, 0);
        checkOutput("rep_doutZero", M68K_DOUT, 0);
        Z80_WR = 1; Z80_DIN = 8'h50;
        applyStimulus();
        Z80_WR = 1; Z80_DIN = 8'h51; M68K_RD = 1;
        applyStimulus();
        checkOutput("rep_ppHead", M68K_DOUT, 8'h51);
        checkOutput("rep_ppOvf", REP_OVF, 0);
        checkOutput("rep_ppFull", REP_FULL, 1);

        // reset mid-operation
        Z80_NMI_EN = 1;
        applyStimulus();
        pushCmd(8'hC1); pushCmd(8'hC2); pushCmd(8'hC3);
        applyStimulus();
        checkOutput("pre_nNMI", nNMI, 0);
        RESET = 1;
        applyStimulus();
        RESET = 0;
        checkResetState("midReset");
        applyStimulus();
        checkOutput("postReset_nNMI", nNMI, 1);
        pushCmd(8'hD0);
        checkOutput("postReset_count", CMD_COUNT, 1);
        checkOutput("postReset_head", Z80_DOUT, 8'hD0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no_finish expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
